mux_nto1_stream: RTL and testbench

MUX_NTO1_STREAM -- requirements
Module: mux_nto1_stream

---
 rtl/mux_nto1_stream.sv | 155 +++++++++++++++
 tb/tb_mux_nto1_stream.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_stream.sv
// N-to-1 stream multiplexer with a one-deep registered output stage, external-select or round-robin grant.
// Optional packet lock (holds the grant until in_last) is enabled by defining MUX_NTO1_STREAM_LOCK_EN.
module mux_nto1_stream #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [$clog2(N)-1:0] sel,
   input  logic [N-1:0]         in_valid,
   input  logic [N*W-1:0]       in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_ch,
   input  logic                 out_ready
`ifdef MUX_NTO1_STREAM_LOCK_EN
   ,
   input  logic [N-1:0]         in_last,
   output logic                 out_last
`endif
);

   localparam int SW = $clog2(N);

   logic          load, xfer, grantOk, baseOk, lastBeat;
   logic [SW-1:0] grant, baseGrant, rrGrant, ptr_q, ptr_d;
   logic [W-1:0]  selData;
   logic          outValid_q, outValid_d;
   logic [W-1:0]  outData_q, outData_d;
   logic [SW-1:0] outCh_q, outCh_d;

   // Round-robin search walks downward so the lowest offset from ptr wins.
   always_comb begin
      rrGrant = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (in_valid[(int'(ptr_q) + k) % N]) begin
            rrGrant = SW'((int'(ptr_q) + k) % N);
         end
      end
   end

   always_comb begin
      baseGrant = rrGrant;
      baseOk    = |in_valid;
      if (MODE == 0) begin
         baseGrant = sel;
         baseOk    = (32'(sel) < N);
      end
   end

`ifdef MUX_NTO1_STREAM_LOCK_EN
   typedef enum logic {IDLE, LOCKED} lockState_t;
   lockState_t    state_q, state_d;
   logic [SW-1:0] lockCh_q, lockCh_d;
   logic          outLast_q, outLast_d;

   assign grant    = (state_q == LOCKED) ? lockCh_q : baseGrant;
   assign grantOk  = (state_q == LOCKED) ? 1'b1 : baseOk;
   assign lastBeat = in_last[grant];
   assign out_last = outLast_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         lockCh_q  <= '0;
         outLast_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lockCh_q  <= lockCh_d;
         outLast_q <= outLast_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lockCh_d  = lockCh_q;
      outLast_d = outLast_q;
      if (xfer) begin
         outLast_d = lastBeat;
      end
      unique case (state_q)
         IDLE: begin
            if (xfer && !lastBeat) begin
               state_d  = LOCKED;
               lockCh_d = grant;
            end
         end
         LOCKED: begin
            if (xfer && lastBeat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
`else
   assign grant    = baseGrant;
   assign grantOk  = baseOk;
   assign lastBeat = 1'b1;
`endif

   assign load = ~outValid_q | out_ready;

   always_comb begin
      in_ready = '0;
      selData  = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = load & grantOk & ~rst & (grant == SW'(i));
         if (grant == SW'(i)) begin
            selData = in_data[i*W +: W];
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   // A transfer always refills the output stage, which also covers drain-and-load in one cycle.
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outCh_d    = outCh_q;
      ptr_d      = ptr_q;
      if (xfer) begin
         outValid_d = 1'b1;
         outData_d  = selData;
         outCh_d    = grant;
         if (MODE == 1 && lastBeat) begin
            ptr_d = (32'(grant) == N - 1) ? '0 : grant + SW'(1);
         end
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outCh_q    <= '0;
         ptr_q      <= '0;
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outCh_q    <= outCh_d;
         ptr_q      <= ptr_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_ch    = outCh_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream: select instance (N=4), round-robin instance (N=4), select instance (N=5).
// Lock scenarios are exercised when MUX_NTO1_STREAM_LOCK_EN is defined.
module tb_mux_nto1_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic [1:0]  selA = '0, ochA, selB = '0, ochB;
   logic [3:0]  validA = '0, readyA, validB = '0, readyB;
   logic [31:0] dataA = '0, dataB = '0;
   logic [7:0]  odA, odB, odC;
   logic        ovA, ovB, ovC, orA = 1'b1, orB = 1'b1, orC = 1'b1;
   logic [2:0]  selC = '0, ochC;
   logic [4:0]  validC = '0, readyC;
   logic [39:0] dataC = '0;
   logic [3:0]  lastA = 4'hF, lastB = 4'hF;
   logic [4:0]  lastC = 5'h1F;
   logic        olA, olB, olC;

   mux_nto1_stream #(.N(4), .W(8), .MODE(0)) dutA (
      .clk(clk), .rst(rst), .sel(selA), .in_valid(validA), .in_data(dataA), .in_ready(readyA),
      .out_valid(ovA), .out_data(odA), .out_ch(ochA), .out_ready(orA)
`ifdef MUX_NTO1_STREAM_LOCK_EN
      , .in_last(lastA), .out_last(olA)
`endif
   );

   mux_nto1_stream #(.N(4), .W(8), .MODE(1)) dutB (
      .clk(clk), .rst(rst), .sel(selB), .in_valid(validB), .in_data(dataB), .in_ready(readyB),
      .out_valid(ovB), .out_data(odB), .out_ch(ochB), .out_ready(orB)
`ifdef MUX_NTO1_STREAM_LOCK_EN
      , .in_last(lastB), .out_last(olB)
`endif
   );

   // Five channels leave spare select codes, so an out-of-range select is actually drivable.
   mux_nto1_stream #(.N(5), .W(8), .MODE(0)) dutC (
      .clk(clk), .rst(rst), .sel(selC), .in_valid(validC), .in_data(dataC), .in_ready(readyC),
      .out_valid(ovC), .out_data(odC), .out_ch(ochC), .out_ready(orC)
`ifdef MUX_NTO1_STREAM_LOCK_EN
      , .in_last(lastC), .out_last(olC)
`endif
   );

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; validA = 4'b0001; selA = 2'd0; orA = 1'b1;
      #1;
      total++; if (readyA !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0000", readyA); end
      @(posedge clk); #1;
      total++; if (ovA !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", ovA); end
      total++; if (odA !== 8'h00 || ochA !== 2'd0) begin bad++; $display("[TB] FAIL reset_data got=%h/%0d want=00/0", odA, ochA); end
      total++; if (ovB !== 1'b0 || ovC !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_bc got=%b%b want=00", ovB, ovC); end
      @(negedge clk);
      rst = 1'b0; validA = '0;
   endtask

   task automatic test_select();
      logic [1:0] sels [3] = '{2'd2, 2'd0, 2'd3};
      logic [7:0] exps [3] = '{8'hA5, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         selA = sels[i]; validA = 4'b0001 << sels[i]; dataA = 32'h33A51122; orA = 1'b1;
         #1;
         total++; if (readyA !== (4'b0001 << sels[i])) begin bad++; $display("[TB] FAIL sel_ready[%0d] got=%b want=%b", i, readyA, 4'b0001 << sels[i]); end
         @(posedge clk); #1;
         total++; if (ovA !== 1'b1 || odA !== exps[i] || ochA !== sels[i]) begin
            bad++; $display("[TB] FAIL sel_beat[%0d] got=%b/%h/%0d want=1/%h/%0d", i, ovA, odA, ochA, exps[i], sels[i]);
         end
         @(negedge clk);
         validA = '0;
         @(posedge clk); #1;
         total++; if (ovA !== 1'b0) begin bad++; $display("[TB] FAIL sel_drain[%0d] got=%b want=0", i, ovA); end
      end
   endtask

   task automatic test_stall();
      @(negedge clk);
      selA = 2'd1; validA = 4'b0010; dataA = 32'h0000_3C00; orA = 1'b0;
      @(posedge clk); #1;
      total++; if (ovA !== 1'b1 || odA !== 8'h3C) begin bad++; $display("[TB] FAIL stall_load got=%b/%h want=1/3c", ovA, odA); end
      @(negedge clk);
      dataA = 32'h0000_7700;
      repeat (3) begin
         #1;
         total++; if (readyA !== 4'b0000) begin bad++; $display("[TB] FAIL stall_ready got=%b want=0000", readyA); end
         @(posedge clk); #1;
         total++; if (ovA !== 1'b1 || odA !== 8'h3C || ochA !== 2'd1) begin
            bad++; $display("[TB] FAIL stall_hold got=%b/%h/%0d want=1/3c/1", ovA, odA, ochA);
         end
         @(negedge clk);
      end
      orA = 1'b1;
      #1;
      total++; if (readyA !== 4'b0010) begin bad++; $display("[TB] FAIL stall_release_ready got=%b want=0010", readyA); end
      @(posedge clk); #1;
      total++; if (ovA !== 1'b1 || odA !== 8'h77) begin bad++; $display("[TB] FAIL stall_next got=%b/%h want=1/77", ovA, odA); end
      @(negedge clk);
      validA = '0;
      @(posedge clk); #1;
      total++; if (ovA !== 1'b0) begin bad++; $display("[TB] FAIL stall_drain got=%b want=0", ovA); end
   endtask

   task automatic test_round_robin();
      logic [1:0] wrapSeq [3] = '{2'd3, 2'd1, 2'd3};
      @(negedge clk);
      validB = 4'b1111; dataB = 32'h13121110; orB = 1'b1; lastB = 4'hF;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         total++; if (ovB !== 1'b1 || ochB !== 2'(i % 4) || odB !== 8'(8'h10 + i % 4)) begin
            bad++; $display("[TB] FAIL rr_all[%0d] got=%b/%0d/%h want=1/%0d/%h", i, ovB, ochB, odB, i % 4, 8'h10 + i % 4);
         end
      end
      @(negedge clk);
      validB = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (ovB !== 1'b1 || ochB !== wrapSeq[i]) begin
            bad++; $display("[TB] FAIL rr_wrap[%0d] got=%b/%0d want=1/%0d", i, ovB, ochB, wrapSeq[i]);
         end
      end
      @(negedge clk);
      validB = '0;
      @(posedge clk); #1;
      total++; if (ovB !== 1'b0) begin bad++; $display("[TB] FAIL rr_drain got=%b want=0", ovB); end
   endtask

   task automatic test_bad_select();
      @(negedge clk);
      selC = 3'd5; validC = 5'b11111; dataC = 40'h55_44_33_22_11; orC = 1'b1;
      #1;
      total++; if (readyC !== 5'b00000) begin bad++; $display("[TB] FAIL badsel5_ready got=%b want=00000", readyC); end
      repeat (3) begin
         @(posedge clk); #1;
         total++; if (ovC !== 1'b0) begin bad++; $display("[TB] FAIL badsel5_valid got=%b want=0", ovC); end
      end
      @(negedge clk);
      selC = 3'd7;
      #1;
      total++; if (readyC !== 5'b00000) begin bad++; $display("[TB] FAIL badsel7_ready got=%b want=00000", readyC); end
      @(negedge clk);
      selC = 3'd4;
      #1;
      total++; if (readyC !== 5'b10000) begin bad++; $display("[TB] FAIL sel4_ready got=%b want=10000", readyC); end
      @(posedge clk); #1;
      total++; if (ovC !== 1'b1 || ochC !== 3'd4 || odC !== 8'h55) begin
         bad++; $display("[TB] FAIL sel4_beat got=%b/%0d/%h want=1/4/55", ovC, ochC, odC);
      end
      @(negedge clk);
      validC = '0;
   endtask

   task automatic test_reset_mid();
      pulseReset();
      validB = 4'b0100; dataB = 32'h00C2_0000; lastB = 4'b0000; orB = 1'b0;
      @(posedge clk); #1;
      total++; if (ovB !== 1'b1 || ochB !== 2'd2) begin bad++; $display("[TB] FAIL rstmid_load got=%b/%0d want=1/2", ovB, ochB); end
      @(negedge clk);
      rst = 1'b1; orB = 1'b1;
      #1;
      total++; if (readyB !== 4'b0000) begin bad++; $display("[TB] FAIL rstmid_ready got=%b want=0000", readyB); end
      @(posedge clk); #1;
      total++; if (ovB !== 1'b0 || odB !== 8'h00 || ochB !== 2'd0) begin
         bad++; $display("[TB] FAIL rstmid_clear got=%b/%h/%0d want=0/00/0", ovB, odB, ochB);
      end
`ifdef MUX_NTO1_STREAM_LOCK_EN
      total++; if (olB !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_last got=%b want=0", olB); end
`endif
      @(negedge clk);
      rst = 1'b0; validB = 4'b1111; lastB = 4'hF; dataB = 32'h13121110;
      #1;
      total++; if (readyB !== 4'b0001) begin bad++; $display("[TB] FAIL rstmid_ptr_ready got=%b want=0001", readyB); end
      @(posedge clk); #1;
      total++; if (ovB !== 1'b1 || ochB !== 2'd0) begin bad++; $display("[TB] FAIL rstmid_first got=%b/%0d want=1/0", ovB, ochB); end
      @(negedge clk);
      validB = '0;
   endtask

`ifdef MUX_NTO1_STREAM_LOCK_EN
   task automatic test_lock();
      logic [1:0] chSeq [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
      logic [7:0] dSeq  [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB2};
      logic       lSeq  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      pulseReset();
      validB = 4'b0110; lastB = 4'b0100; dataB = 32'h00B2_A100; orB = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if (ovB !== 1'b1 || ochB !== chSeq[i] || odB !== dSeq[i] || olB !== lSeq[i]) begin
            bad++; $display("[TB] FAIL lock_beat[%0d] got=%b/%0d/%h/%b want=1/%0d/%h/%b", i, ovB, ochB, odB, olB, chSeq[i], dSeq[i], lSeq[i]);
         end
         @(negedge clk);
         if (i == 0) begin
            dataB = 32'h00B2_A200;
            #1;
            total++; if (readyB !== 4'b0010) begin bad++; $display("[TB] FAIL lock_ready got=%b want=0010", readyB); end
         end else if (i == 1) begin
            dataB = 32'h00B2_A300; lastB = 4'b0110;
         end else if (i == 2) begin
            validB = 4'b0100;
         end else begin
            validB = '0;
         end
      end
      @(posedge clk); #1;
      total++; if (ovB !== 1'b0) begin bad++; $display("[TB] FAIL lock_drain got=%b want=0", ovB); end
      lastB = 4'hF;
   endtask
`endif

   initial begin
      test_reset();
      test_select();
      test_stall();
      test_round_robin();
      test_bad_select();
      test_reset_mid();
`ifdef MUX_NTO1_STREAM_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
